control_unit: RTL and testbench



---
 rtl/control_unit_pkg.sv | 37 +++
 rtl/control_unit_if.sv | 29 ++
 rtl/control_unit_step_counter.sv | 17 +
 rtl/control_unit.sv | 140 ++++++++++++++
 tb/tb_control_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// cpu_defs: shared definitions for the Mini SRC hardwired control unit.
//   - opcode values (IR[31:27])
//   - step encodings T0..T7 and the controller phase enum
//   - ctrl_t: the full strobe bundle driven onto the DataPath
//   - has_exec(): whether an opcode has any execute steps after fetch
package cpu_defs;
  localparam int OPCODE_W  = 5;
  localparam int LAST_STEP = 7;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                         OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                         OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                         OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                         OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                         OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001,
                         OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100,
                         OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                         OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010,
                         OP_HALT = 5'b11011;

  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
                         T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7;

  typedef enum logic [1:0] {PH_FETCH = 2'd0, PH_EXEC = 2'd1, PH_HALTED = 2'd2} phase_e;

  // Field order matches the concatenation onto the interface in control_unit.
  typedef struct packed {
    logic Write, Read, IncPC, CONin, OutPortin, LOin, HIin, Yin, IRin, MDRin,
          PCin, Zin, MARin, BAout, Rout, Rin, Grc, Grb, Gra, Cout, InPortout,
          LOout, HIout, MDRout, Zlowout, Zhighout, PCout;
  } ctrl_t;

  // jal, nop and the codes above halt have no execute steps (fetch only).
  function automatic logic has_exec(input logic [OPCODE_W-1:0] op);
    return (op <= OP_HALT) && (op != OP_JAL) && (op != OP_NOP);
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: control interface between the control unit (master)
// and the Mini SRC DataPath (slave).
//   DataPath -> control: Stop, IR[31:0], CON_FF
//   control -> DataPath: Run, bus drivers, register selects, register
//                        loads, IncPC/Read/Write, alu_op[OPW-1:0]
interface control_unit_if import cpu_defs::*; #(parameter int OPW = OPCODE_W);
  logic           Stop, CON_FF, Run;
  logic [31:0]    IR;
  logic           PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout;
  logic           Gra, Grb, Grc, Rin, Rout, BAout;
  logic           MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin;
  logic           IncPC, Read, Write;
  logic [OPW-1:0] alu_op;

  modport master (
    input  Stop, IR, CON_FF,
    output Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout,
           MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin,
           IncPC, Read, Write, alu_op
  );
  modport slave (
    output Stop, IR, CON_FF,
    input  Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout,
           MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin,
           IncPC, Read, Write, alu_op
  );
endinterface

// File: rtl/control_unit_step_counter.sv
// step_counter: 3-bit T-step counter.
//   Clock, Reset (sync, active-high) -> step = T0
//   clear   : return to T0 (instruction boundary / halt)
//   advance : step + 1
//   step    : current step index
module step_counter import cpu_defs::*; (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] step
);
  always_ff @(posedge Clock) begin
    if (Reset || clear) step <= T0;
    else if (advance)   step <= step + 3'd1;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore controller for the Mini SRC single-bus
// datapath. Fetches (T0..T2), then sequences the execute steps (T3..T7)
// of the opcode latched from IR[31:27].
//   Clock, Reset : clock, synchronous active-high reset
//   bus          : master end of control_unit_if (Stop/IR/CON_FF in,
//                  Run, strobes and alu_op out)
module control_unit import cpu_defs::*; #(
  parameter int OPW     = OPCODE_W,
  parameter int MAXSTEP = LAST_STEP
) (
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);
  phase_e         phase_q, phase_d;
  logic [2:0]     step;
  logic           clr, adv, last, stop_pend;
  logic [OPW-1:0] opc_q, ir_op, alu;
  ctrl_t          c;

  assign ir_op = bus.IR[31 -: OPW];

  step_counter u_step (.Clock(Clock), .Reset(Reset), .clear(clr), .advance(adv), .step(step));

  // The opcode is captured on the edge that enters T3, so every execute
  // step (including T3) decodes from registered state only.
  // A Stop request is remembered until the instruction boundary; once
  // HALTED only Reset leaves, so the flag never needs clearing otherwise.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q   <= PH_FETCH;
      opc_q     <= '0;
      stop_pend <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (phase_q == PH_FETCH && step == T2) opc_q <= ir_op;
      if (bus.Stop) stop_pend <= 1'b1;
    end
  end

  always_comb begin
    c = '0; alu = '0; last = 1'b0;
    phase_d = phase_q; clr = 1'b0; adv = 1'b0;
    case (phase_q)
      PH_FETCH: case (step)
        T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
        T1: begin c.Zlowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
        // IR is loaded on this edge; the opcode only steers the next state.
        T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; last = !has_exec(ir_op); end
        default: last = 1'b1;
      endcase
      PH_EXEC: begin
        case (opc_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: case (step)
            T3: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
            T4: begin
              c.Zin = 1'b1;
              case (opc_q)
                OP_ADDI: begin c.Cout = 1'b1; alu = OP_ADD; end
                OP_ANDI: begin c.Cout = 1'b1; alu = OP_AND; end
                OP_ORI:  begin c.Cout = 1'b1; alu = OP_OR;  end
                default: begin c.Grc = 1'b1; c.Rout = 1'b1; alu = opc_q; end
              endcase
            end
            default: begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; last = 1'b1; end
          endcase
          OP_NEG, OP_NOT: case (step)
            T3: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; alu = opc_q; end
            default: begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; last = 1'b1; end
          endcase
          OP_LD, OP_LDI, OP_ST: case (step)
            T3: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
            T4: begin c.Cout = 1'b1; c.Zin = 1'b1; alu = OP_ADD; end
            T5: begin
              c.Zlowout = 1'b1;
              if (opc_q == OP_LDI) begin c.Gra = 1'b1; c.Rin = 1'b1; last = 1'b1; end
              else c.MARin = 1'b1;
            end
            T6: begin
              c.MDRin = 1'b1;
              if (opc_q == OP_LD) c.Read = 1'b1;
              else begin c.Gra = 1'b1; c.Rout = 1'b1; end
            end
            default: begin
              if (opc_q == OP_LD) begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
              else c.Write = 1'b1;
              last = 1'b1;
            end
          endcase
          OP_MUL, OP_DIV: case (step)
            T3: begin c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
            T4: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; alu = opc_q; end
            T5: begin c.Zlowout = 1'b1; c.LOin = 1'b1; end
            default: begin c.Zhighout = 1'b1; c.HIin = 1'b1; last = 1'b1; end
          endcase
          OP_BR: case (step)
            T3: begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
            T4: begin c.PCout = 1'b1; c.Yin = 1'b1; end
            T5: begin c.Cout = 1'b1; c.Zin = 1'b1; alu = OP_ADD; end
            // The only combinational input-to-strobe path in the block.
            default: begin c.Zlowout = 1'b1; c.PCin = bus.CON_FF; last = 1'b1; end
          endcase
          OP_JR:   begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; last = 1'b1; end
          OP_IN:   begin c.InPortout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; last = 1'b1; end
          OP_OUT:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.OutPortin = 1'b1; last = 1'b1; end
          OP_MFHI: begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; last = 1'b1; end
          OP_MFLO: begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; last = 1'b1; end
          OP_HALT: ;
          default: last = 1'b1;
        endcase
        // Never run past the top step, whatever the opcode.
        if (step == 3'(MAXSTEP)) last = 1'b1;
      end
      default: ;
    endcase

    if (phase_q == PH_EXEC && opc_q == OP_HALT) begin
      phase_d = PH_HALTED; clr = 1'b1;
    end else if (phase_q != PH_HALTED) begin
      if (last) begin
        phase_d = (bus.Stop || stop_pend) ? PH_HALTED : PH_FETCH;
        clr     = 1'b1;
      end else begin
        adv = 1'b1;
        if (phase_q == PH_FETCH && step == T2) phase_d = PH_EXEC;
      end
    end

    // Strobes are held low for the whole Reset cycle even mid-instruction.
    if (Reset) begin c = '0; alu = '0; end
  end

  assign bus.Run = Reset || (phase_q != PH_HALTED);
  assign {bus.Write, bus.Read, bus.IncPC, bus.CONin, bus.OutPortin, bus.LOin, bus.HIin,
          bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.Zin, bus.MARin, bus.BAout, bus.Rout,
          bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Cout, bus.InPortout, bus.LOout, bus.HIout,
          bus.MDRout, bus.Zlowout, bus.Zhighout, bus.PCout} = c;
  assign bus.alu_op = alu;
endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int vecs = 0, miss = 0;
  logic [32:0] exp_q[$];

  localparam logic [26:0]
    PCOUT = 27'd1 << 0,  ZHIGH = 27'd1 << 1,  ZLOW  = 27'd1 << 2,  MDROUT = 27'd1 << 3,
    HIOUT = 27'd1 << 4,  LOOUT = 27'd1 << 5,  INPRT = 27'd1 << 6,  COUT   = 27'd1 << 7,
    GRA   = 27'd1 << 8,  GRB   = 27'd1 << 9,  GRC   = 27'd1 << 10, RIN    = 27'd1 << 11,
    ROUT  = 27'd1 << 12, BAOUT = 27'd1 << 13, MARIN = 27'd1 << 14, ZIN    = 27'd1 << 15,
    PCIN  = 27'd1 << 16, MDRIN = 27'd1 << 17, IRIN  = 27'd1 << 18, YIN    = 27'd1 << 19,
    HIIN  = 27'd1 << 20, LOIN  = 27'd1 << 21, OUTIN = 27'd1 << 22, CONIN  = 27'd1 << 23,
    INCPC = 27'd1 << 24, READ  = 27'd1 << 25, WRITE = 27'd1 << 26;
  // Observed/expected vector: {Run, alu_op, strobes}
  localparam logic [32:0] RST_V  = {1'b1, 32'd0};
  localparam logic [32:0] HALT_V = 33'd0;
  localparam logic [32:0] F0_V   = {1'b1, 5'd0, PCOUT | MARIN | INCPC | ZIN};

  always #5 Clock = ~Clock;

  control_unit_if bus();
  control_unit dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  task automatic push(input logic [26:0] m, input int a);
    exp_q.push_back({1'b1, 5'(a), m});
  endtask

  // Reference micro-program: the full per-cycle strobe sequence of one
  // instruction, written straight from the instruction tables.
  task automatic model(input int op, input bit con);
    exp_q.delete();
    push(PCOUT | MARIN | INCPC | ZIN, 0);
    push(ZLOW | PCIN | READ | MDRIN, 0);
    push(MDROUT | IRIN, 0);
    if (op inside {3, 4, 5, 6, 7, 8, 9, 10, 11}) begin
      push(GRB | ROUT | YIN, 0); push(GRC | ROUT | ZIN, op); push(ZLOW | GRA | RIN, 0);
    end else if (op inside {17, 18}) begin
      push(GRB | ROUT | ZIN, op); push(ZLOW | GRA | RIN, 0);
    end else if (op inside {12, 13, 14}) begin
      push(GRB | ROUT | YIN, 0); push(COUT | ZIN, op == 12 ? 3 : op == 13 ? 5 : 6);
      push(ZLOW | GRA | RIN, 0);
    end else if (op inside {0, 1, 2}) begin
      push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 3);
      if (op == 1) push(ZLOW | GRA | RIN, 0);
      else begin
        push(ZLOW | MARIN, 0);
        if (op == 0) begin push(READ | MDRIN, 0); push(MDROUT | GRA | RIN, 0); end
        else begin push(GRA | ROUT | MDRIN, 0); push(WRITE, 0); end
      end
    end else if (op inside {15, 16}) begin
      push(GRA | ROUT | YIN, 0); push(GRB | ROUT | ZIN, op);
      push(ZLOW | LOIN, 0); push(ZHIGH | HIIN, 0);
    end else if (op == 19) begin
      push(GRA | ROUT | CONIN, 0); push(PCOUT | YIN, 0); push(COUT | ZIN, 3);
      push(ZLOW | (con ? PCIN : 27'd0), 0);
    end
    else if (op == 20) push(GRA | ROUT | PCIN, 0);
    else if (op == 22) push(INPRT | GRA | RIN, 0);
    else if (op == 23) push(GRA | ROUT | OUTIN, 0);
    else if (op == 24) push(HIOUT | GRA | RIN, 0);
    else if (op == 25) push(LOOUT | GRA | RIN, 0);
    else if (op == 27) push(27'd0, 0);
  endtask

  // Entered just after a falling edge; drives this cycle's inputs,
  // samples the outputs, then waits for the next falling edge.
  task automatic step(input bit stop, input bit con, output logic [32:0] obs);
    bus.Stop = stop; bus.CON_FF = con;
    #1;
    obs = {bus.Run, bus.alu_op, bus.Write, bus.Read, bus.IncPC, bus.CONin, bus.OutPortin,
           bus.LOin, bus.HIin, bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.Zin, bus.MARin,
           bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Cout, bus.InPortout,
           bus.LOout, bus.HIout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.PCout};
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1; bus.Stop = 1'b0;
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [32:0] obs;
    bus.IR = 32'h28918000;
    for (int k = 0; k < 2; k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== RST_V) begin miss++; $display("FAIL reset k=%0d got %h want %h", k, obs, RST_V); end
    end
    Reset = 1'b0;
  endtask

  task automatic test_and();
    logic [32:0] obs;
    model(5, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== exp_q[k]) begin miss++; $display("FAIL and k=%0d got %h want %h", k, obs, exp_q[k]); end
    end
    step(0, 0, obs); vecs++;
    if (obs !== F0_V) begin miss++; $display("FAIL and_next got %h want %h", obs, F0_V); end
  endtask

  task automatic test_ld();
    logic [32:0] obs;
    do_reset(); bus.IR = 32'h00800055; model(0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== exp_q[k]) begin miss++; $display("FAIL ld k=%0d got %h want %h", k, obs, exp_q[k]); end
    end
    step(0, 0, obs); vecs++;
    if (obs !== F0_V) begin miss++; $display("FAIL ld_next got %h want %h", obs, F0_V); end
  endtask

  task automatic test_st();
    logic [32:0] obs;
    do_reset(); bus.IR = {5'b00010, 27'h0880010}; model(2, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== exp_q[k]) begin miss++; $display("FAIL st k=%0d got %h want %h", k, obs, exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] obs;
    do_reset(); bus.IR = {5'b10011, 27'h0180040};
    for (int pass = 0; pass < 2; pass++) begin
      model(19, pass == 0);
      for (int k = 0; k < exp_q.size(); k++) begin
        step(0, pass == 0, obs); vecs++;
        if (obs !== exp_q[k]) begin miss++; $display("FAIL br%0d k=%0d got %h want %h", pass, k, obs, exp_q[k]); end
      end
    end
    step(0, 0, obs); vecs++;
    if (obs !== F0_V) begin miss++; $display("FAIL br_next got %h want %h", obs, F0_V); end
  endtask

  task automatic test_stop();
    logic [32:0] obs;
    do_reset(); bus.IR = {5'b00011, 27'h0918000}; model(3, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      step(k == 4, 0, obs); vecs++;
      if (obs !== exp_q[k]) begin miss++; $display("FAIL stop k=%0d got %h want %h", k, obs, exp_q[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 1, obs); vecs++;
      if (obs !== HALT_V) begin miss++; $display("FAIL stop_halted k=%0d got %h want %h", k, obs, HALT_V); end
    end
  endtask

  task automatic test_halt();
    logic [32:0] obs;
    do_reset(); bus.IR = {5'b11011, 27'd0}; model(27, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== exp_q[k]) begin miss++; $display("FAIL halt k=%0d got %h want %h", k, obs, exp_q[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== HALT_V) begin miss++; $display("FAIL halted k=%0d got %h want %h", k, obs, HALT_V); end
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] obs;
    do_reset(); bus.IR = {5'b00010, 27'h0880010}; model(2, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== exp_q[k]) begin miss++; $display("FAIL rmid k=%0d got %h want %h", k, obs, exp_q[k]); end
    end
    Reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== RST_V) begin miss++; $display("FAIL rmid_reset k=%0d got %h want %h", k, obs, RST_V); end
    end
    Reset = 1'b0;
    bus.IR = 32'hF8000000; model(31, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      step(0, 0, obs); vecs++;
      if (obs !== exp_q[k]) begin miss++; $display("FAIL undef k=%0d got %h want %h", k, obs, exp_q[k]); end
    end
    step(0, 0, obs); vecs++;
    if (obs !== F0_V) begin miss++; $display("FAIL undef_next got %h want %h", obs, F0_V); end
  endtask

  task automatic test_random();
    logic [32:0] obs;
    int op, sk;
    bit con;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op  = $urandom_range(0, 31);
      con = 1'($urandom_range(0, 1));
      model(op, con);
      sk  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
      bus.IR = {5'(op), 27'($urandom)};
      for (int k = 0; k < exp_q.size(); k++) begin
        step(k == sk, con, obs); vecs++;
        if (obs !== exp_q[k]) begin miss++; $display("FAIL rand op=%0d k=%0d got %h want %h", op, k, obs, exp_q[k]); end
      end
      if (op == 27 || sk >= 0) begin
        for (int k = 0; k < 2; k++) begin
          step(0, con, obs); vecs++;
          if (obs !== HALT_V) begin miss++; $display("FAIL rand_halted op=%0d got %h want %h", op, obs, HALT_V); end
        end
        do_reset();
      end
    end
  endtask

  initial begin
    bus.Stop = 1'b0; bus.CON_FF = 1'b0; bus.IR = 32'd0;
    @(negedge Clock);
    test_reset();
    test_and();
    test_ld();
    test_st();
    test_back_to_back();
    test_stop();
    test_halt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
